sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Multiplexed scan controller for a four-digit, common-anode seven-segment
// display. The digits are lit one at a time, right to left in index order
// 0,1,2,3. A short all-off guard gap separates two digits so that neither
// digit shows ghosting of the other's segments.
//
// A new value is accepted into a pending register. It is copied into the
// displayed register only at a frame boundary, so one scan frame never
// mixes digits from two different values.
//
// Parameters
//   DIGIT_CYC  clock cycles each digit is driven per scan slot (>= 16)
//   GUARD_CYC  all-digits-off cycles between slots (>= 1)
//
// Ports
//   i_clk       sole clock, all state on the rising edge
//   i_reset_n   asynchronous active-low reset
//   i_load      load request, accepted only while o_ready is high
//   i_value     four hex nibbles; nibble k drives digit k (digit 0 rightmost)
//   i_dp        decimal-point enables per digit, sampled with i_value
//   i_blank_lz  leading-zero blanking enable (live)
//   i_bright    brightness 0 (off) .. 15 (full) (live)
//   o_ready     high when a load can be accepted
//   o_ldsel     active-low digit select, one-cold or all-high
//   o_sseg_n    active-low segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int DIGIT_CYC = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  input  logic [3:0]  i_bright,
  output logic        o_ready,
  output logic [3:0]  o_ldsel,
  output logic [7:0]  o_sseg_n
);

  // One counter serves both phases, so it is sized for the longer one.
  // DIGIT_CYC >= 16 guarantees at least four bits, which the brightness
  // PWM compare needs.
  localparam int MAX_CYC = (DIGIT_CYC > GUARD_CYC) ? DIGIT_CYC : GUARD_CYC;
  localparam int CNT_W   = (MAX_CYC > 16) ? $clog2(MAX_CYC) : 4;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [15:0]      disp_value;
  logic [3:0]       disp_dp;
  logic [15:0]      pend_value;
  logic [3:0]       pend_dp;
  logic             pend_valid;

  logic             load_accept;
  logic             drive_last;
  logic             guard_last;
  logic             frame_end;
  logic [3:0]       cur_nibble;
  logic             cur_dp;
  logic             upper_zero;
  logic             bright_on;
  logic             lit;
  logic [6:0]       seg_code;
  logic [3:0]       ldsel_next;
  logic [7:0]       sseg_next;

  // Hex to active-low {g,f,e,d,c,b,a}. The decimal point is added separately.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // A load can only be pending one at a time, so ready is simply the
  // absence of a pending value. pend_valid is a flop, so this does not glitch.
  assign o_ready     = ~pend_valid;
  assign load_accept = i_load & ~pend_valid;

  assign drive_last  = (cnt == DIGIT_LAST);
  assign guard_last  = (cnt == GUARD_LAST);

  // The frame ends on the last guard cycle after digit 3, just before the
  // index wraps back to 0.
  assign frame_end   = (state == ST_GUARD) && guard_last && (idx == 2'd3);

  // Select the nibble and dp for the current digit. Also work out whether
  // that digit and every digit to its left hold zero, which makes it a
  // leading zero. Digit 0 is never a leading zero, so a value of 0 still
  // shows one "0".
  always_comb begin
    cur_nibble = disp_value[3:0];
    cur_dp     = disp_dp[0];
    upper_zero = 1'b0;
    case (idx)
      2'd0: begin
        cur_nibble = disp_value[3:0];
        cur_dp     = disp_dp[0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        cur_nibble = disp_value[7:4];
        cur_dp     = disp_dp[1];
        upper_zero = (disp_value[15:4] == 12'h000);
      end
      2'd2: begin
        cur_nibble = disp_value[11:8];
        cur_dp     = disp_dp[2];
        upper_zero = (disp_value[15:8] == 8'h00);
      end
      default: begin
        cur_nibble = disp_value[15:12];
        cur_dp     = disp_dp[3];
        upper_zero = (disp_value[15:12] == 4'h0);
      end
    endcase
  end

  // Brightness is a PWM over the low four bits of the slot counter. The
  // digit is on for the first i_bright of every 16 drive cycles. Level 15
  // is forced fully on, so full brightness has no one-cycle dark gap.
  assign bright_on = (i_bright == 4'hF) || (cnt[3:0] < i_bright);

  assign lit = (state == ST_DRIVE) && bright_on &&
               !(i_blank_lz && upper_zero);

  assign seg_code = hex_to_seg(cur_nibble);

  // Next values for the output flops. When the digit is not lit, every
  // digit and every segment is switched off, not just the select.
  always_comb begin
    ldsel_next = 4'hF;
    sseg_next  = 8'hFF;
    if (lit) begin
      ldsel_next = ~(4'b0001 << idx);
      sseg_next  = {~cur_dp, seg_code};
    end
  end

  // Scan FSM. It steps the per-slot counter and the digit index. It also
  // registers the digit select and segment drive, so the pins change only
  // on clock edges. Those outputs show the state from one cycle earlier.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_DRIVE;
      cnt      <= '0;
      idx      <= 2'd0;
      o_ldsel  <= 4'hF;
      o_sseg_n <= 8'hFF;
    end else begin
      o_ldsel  <= ldsel_next;
      o_sseg_n <= sseg_next;
      case (state)
        ST_DRIVE: begin
          if (drive_last) begin
            state <= ST_GUARD;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        ST_GUARD: begin
          if (guard_last) begin
            state <= ST_DRIVE;
            cnt   <= '0;
            idx   <= idx + 2'd1;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_DRIVE;
          cnt   <= '0;
          idx   <= 2'd0;
        end
      endcase
    end
  end

  // Load and commit path. A load can only be accepted while nothing is
  // pending. So an accept and a commit never happen in the same cycle. A
  // load taken on the frame-boundary cycle therefore waits for the next
  // boundary.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      disp_value <= 16'h0000;
      disp_dp    <= 4'h0;
      pend_value <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_valid <= 1'b0;
    end else begin
      if (load_accept) begin
        pend_value <= i_value;
        pend_dp    <= i_dp;
        pend_valid <= 1'b1;
      end else if (frame_end && pend_valid) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Testbench for sseg_scan_ctrl with DIGIT_CYC=16 and GUARD_CYC=2. A frame is
// then 4 x 18 = 72 cycles.
//
// The reference model does not follow the RTL's state machine. It tracks the
// absolute position inside the frame (0..71) and derives everything from it:
// the slot is pos/18, the offset in the slot is pos%18, and the digit is
// driven while the offset is below 16. It also tracks the displayed value,
// the pending value and the pending flag.
// ---------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

  localparam int DIGIT_CYC = 16;
  localparam int GUARD_CYC = 2;
  localparam int SLOT_CYC  = DIGIT_CYC + GUARD_CYC;
  localparam int FRAME_CYC = 4 * SLOT_CYC;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_value = 16'h0000;
  logic [3:0]  i_dp = 4'h0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  i_bright = 4'hF;
  logic        o_ready;
  logic [3:0]  o_ldsel;
  logic [7:0]  o_sseg_n;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          pos;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [15:0] m_pval;
  logic [3:0]  m_pdp;
  bit          m_pvalid;
  logic [3:0]  exp_ldsel;
  logic [7:0]  exp_sseg;
  logic        exp_ready;

  logic [7:0] seg_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                 8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                 8'hC6, 8'hA1, 8'h86, 8'h8E};

  sseg_scan_ctrl #(
    .DIGIT_CYC(DIGIT_CYC),
    .GUARD_CYC(GUARD_CYC)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (i_load),
    .i_value    (i_value),
    .i_dp       (i_dp),
    .i_blank_lz (i_blank_lz),
    .i_bright   (i_bright),
    .o_ready    (o_ready),
    .o_ldsel    (o_ldsel),
    .o_sseg_n   (o_sseg_n)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    pos       = 0;
    m_val     = 16'h0000;
    m_dp      = 4'h0;
    m_pval    = 16'h0000;
    m_pdp     = 4'h0;
    m_pvalid  = 1'b0;
    exp_ldsel = 4'hF;
    exp_sseg  = 8'hFF;
    exp_ready = 1'b1;
  endtask

  // Work out the outputs the next edge must produce from the current
  // position and inputs. Then clock once, settle and update the model.
  task automatic step();
    int   slot;
    int   off;
    int   nib;
    bit   lit;
    bit   accept;
    bit   wrap;
    slot = pos / SLOT_CYC;
    off  = pos % SLOT_CYC;
    lit  = (off < DIGIT_CYC) &&
           ((i_bright == 4'hF) || ((off % 16) < int'(i_bright))) &&
           !(i_blank_lz && slot > 0 && ((int'(m_val) >> (4 * slot)) == 0));
    nib  = (int'(m_val) >> (4 * slot)) & 15;
    if (lit) begin
      exp_ldsel = 4'hF & ~(4'b0001 << slot);
      exp_sseg  = {~m_dp[slot], seg_tbl[nib][6:0]};
    end else begin
      exp_ldsel = 4'hF;
      exp_sseg  = 8'hFF;
    end
    accept = i_load && !m_pvalid;
    wrap   = (pos == FRAME_CYC - 1);
    @(posedge i_clk);
    #1;
    if (accept) begin
      m_pval   = i_value;
      m_pdp    = i_dp;
      m_pvalid = 1'b1;
    end else if (wrap && m_pvalid) begin
      m_val    = m_pval;
      m_dp     = m_pdp;
      m_pvalid = 1'b0;
    end
    pos       = (pos + 1) % FRAME_CYC;
    exp_ready = !m_pvalid;
  endtask

  // Stimulus only: load a value and run until the frame boundary commits it.
  task automatic load_and_commit(input logic [15:0] val, input logic [3:0] dp);
    int n;
    n = 0;
    while (m_pvalid && n < 2 * FRAME_CYC) begin
      step();
      n++;
    end
    i_load  = 1'b1;
    i_value = val;
    i_dp    = dp;
    step();
    i_load = 1'b0;
    while (m_pvalid && n < 4 * FRAME_CYC) begin
      step();
      n++;
    end
    checks++;
    if (m_pvalid) begin
      errors++;
      $display("[TB] FAIL commit_timeout got pending exp committed");
    end
  endtask

  task automatic test_reset();
    #7;
    checks += 3;
    if (o_ldsel !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_ldsel got %h exp F", o_ldsel);
    end
    if (o_sseg_n !== 8'hFF) begin
      errors++; $display("[TB] FAIL reset_sseg got %h exp FF", o_sseg_n);
    end
    if (o_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready got %b exp 1", o_ready);
    end
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_scan();
    int lit_cnt;
    lit_cnt = 0;
    i_bright   = 4'hF;
    i_blank_lz = 1'b0;
    for (int n = 0; n < 2 * FRAME_CYC; n++) begin
      step();
      if (o_ldsel != 4'hF) lit_cnt++;
      checks += 3;
      if (o_ldsel !== exp_ldsel) begin
        errors++; $display("[TB] FAIL scan_ldsel pos=%0d got %h exp %h", pos, o_ldsel, exp_ldsel);
      end
      if (o_sseg_n !== exp_sseg) begin
        errors++; $display("[TB] FAIL scan_sseg pos=%0d got %h exp %h", pos, o_sseg_n, exp_sseg);
      end
      if (o_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL scan_ready pos=%0d got %b exp %b", pos, o_ready, exp_ready);
      end
    end
    checks++;
    if (lit_cnt != 2 * 4 * DIGIT_CYC) begin
      errors++; $display("[TB] FAIL scan_lit_cycles got %0d exp %0d", lit_cnt, 2 * 4 * DIGIT_CYC);
    end
  endtask

  task automatic test_load();
    i_bright = 4'hF;
    while (pos != 30) step();
    i_load  = 1'b1;
    i_value = 16'h12AF;
    i_dp    = 4'b0001;
    step();
    i_load = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL load_ready_drop got %b exp 0", o_ready);
    end
    // A second request while busy must be ignored.
    i_load  = 1'b1;
    i_value = 16'h3456;
    i_dp    = 4'b1111;
    step();
    i_load = 1'b0;
    for (int n = 0; n < 2 * FRAME_CYC && pos != 0; n++) begin
      step();
      checks += 3;
      if (o_ldsel !== exp_ldsel) begin
        errors++; $display("[TB] FAIL load_old_ldsel pos=%0d got %h exp %h", pos, o_ldsel, exp_ldsel);
      end
      if (o_sseg_n !== exp_sseg) begin
        errors++; $display("[TB] FAIL load_old_sseg pos=%0d got %h exp %h", pos, o_sseg_n, exp_sseg);
      end
      if (o_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL load_old_ready pos=%0d got %b exp %b", pos, o_ready, exp_ready);
      end
    end
    step();
    checks += 3;
    if (o_sseg_n !== 8'h0E) begin
      errors++; $display("[TB] FAIL load_digit0 got %h exp 0E", o_sseg_n);
    end
    if (o_ldsel !== 4'hE) begin
      errors++; $display("[TB] FAIL load_digit0_sel got %h exp E", o_ldsel);
    end
    if (o_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL load_ready_back got %b exp 1", o_ready);
    end
    for (int n = 0; n < FRAME_CYC; n++) begin
      step();
      checks += 2;
      if (o_ldsel !== exp_ldsel) begin
        errors++; $display("[TB] FAIL load_new_ldsel pos=%0d got %h exp %h", pos, o_ldsel, exp_ldsel);
      end
      if (o_sseg_n !== exp_sseg) begin
        errors++; $display("[TB] FAIL load_new_sseg pos=%0d got %h exp %h", pos, o_sseg_n, exp_sseg);
      end
      if (pos == SLOT_CYC + 1) begin
        checks++;
        if (o_sseg_n !== 8'h88) begin
          errors++; $display("[TB] FAIL load_digit1 got %h exp 88", o_sseg_n);
        end
      end
    end
  endtask

  task automatic test_blank();
    int lit_cnt;
    logic [15:0] vals [2] = '{16'h0005, 16'h0000};
    logic [7:0]  segs [2] = '{8'h92, 8'hC0};
    i_bright   = 4'hF;
    i_blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      load_and_commit(vals[v], 4'h0);
      lit_cnt = 0;
      for (int n = 0; n < FRAME_CYC; n++) begin
        step();
        if (o_ldsel != 4'hF) begin
          lit_cnt++;
          checks++;
          if (o_ldsel !== 4'hE || o_sseg_n !== segs[v]) begin
            errors++; $display("[TB] FAIL blank_digit0 sel=%h sseg=%h exp E/%h", o_ldsel, o_sseg_n, segs[v]);
          end
        end
        checks++;
        if (o_ldsel !== exp_ldsel || o_sseg_n !== exp_sseg) begin
          errors++; $display("[TB] FAIL blank_model pos=%0d got %h/%h exp %h/%h", pos, o_ldsel, o_sseg_n, exp_ldsel, exp_sseg);
        end
      end
      checks++;
      if (lit_cnt != DIGIT_CYC) begin
        errors++; $display("[TB] FAIL blank_lit_cycles got %0d exp %0d", lit_cnt, DIGIT_CYC);
      end
    end
    i_blank_lz = 1'b0;
  endtask

  task automatic test_bright();
    int lit_cnt;
    logic [3:0] levels [3] = '{4'd4, 4'd0, 4'd9};
    i_blank_lz = 1'b0;
    load_and_commit(16'h8421, 4'b1010);
    for (int b = 0; b < 3; b++) begin
      i_bright = levels[b];
      lit_cnt  = 0;
      // Skip one cycle so the new level has taken effect.
      step();
      while (pos != 1) step();
      for (int n = 0; n < FRAME_CYC; n++) begin
        step();
        if (o_ldsel != 4'hF) lit_cnt++;
        checks++;
        if (o_ldsel !== exp_ldsel || o_sseg_n !== exp_sseg) begin
          errors++; $display("[TB] FAIL bright_model lvl=%0d pos=%0d got %h/%h exp %h/%h", levels[b], pos, o_ldsel, o_sseg_n, exp_ldsel, exp_sseg);
        end
      end
      checks++;
      if (lit_cnt != 4 * int'(levels[b])) begin
        errors++; $display("[TB] FAIL bright_lit_cycles lvl=%0d got %0d exp %0d", levels[b], lit_cnt, 4 * int'(levels[b]));
      end
    end
    i_bright = 4'hF;
  endtask

  task automatic test_boundary_reset();
    i_bright = 4'hF;
    while (pos != FRAME_CYC - 1) step();
    i_load  = 1'b1;
    i_value = 16'hBEEF;
    i_dp    = 4'b0110;
    step();
    i_load = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL bnd_ready got %b exp 0", o_ready);
    end
    for (int n = 0; n < 30; n++) begin
      step();
      checks++;
      if (o_ldsel !== exp_ldsel || o_sseg_n !== exp_sseg) begin
        errors++; $display("[TB] FAIL bnd_old_value pos=%0d got %h/%h exp %h/%h", pos, o_ldsel, o_sseg_n, exp_ldsel, exp_sseg);
      end
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks += 3;
    if (o_ldsel !== 4'hF) begin
      errors++; $display("[TB] FAIL async_rst_ldsel got %h exp F", o_ldsel);
    end
    if (o_sseg_n !== 8'hFF) begin
      errors++; $display("[TB] FAIL async_rst_sseg got %h exp FF", o_sseg_n);
    end
    if (o_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL async_rst_ready got %b exp 1", o_ready);
    end
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < FRAME_CYC + 5; n++) begin
      step();
      checks += 2;
      if (o_ldsel !== exp_ldsel || o_sseg_n !== exp_sseg) begin
        errors++; $display("[TB] FAIL post_rst pos=%0d got %h/%h exp %h/%h", pos, o_ldsel, o_sseg_n, exp_ldsel, exp_sseg);
      end
      if (o_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL post_rst_ready pos=%0d got %b exp 1", pos, o_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 20 * FRAME_CYC; n++) begin
      i_load = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      for (int k = 3; k >= 0; k--) begin
        if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
      end
      i_value = v;
      i_dp    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) i_bright = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 31) == 0) i_blank_lz = ~i_blank_lz;
      step();
      checks += 3;
      if (o_ldsel !== exp_ldsel) begin
        errors++; $display("[TB] FAIL rand_ldsel pos=%0d got %h exp %h", pos, o_ldsel, exp_ldsel);
      end
      if (o_sseg_n !== exp_sseg) begin
        errors++; $display("[TB] FAIL rand_sseg pos=%0d got %h exp %h", pos, o_sseg_n, exp_sseg);
      end
      if (o_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL rand_ready pos=%0d got %b exp %b", pos, o_ready, exp_ready);
      end
    end
    i_load = 1'b0;
  endtask

  initial begin
    model_reset();
    $display("[TB] starting sseg_scan_ctrl bench");
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_bright();
    test_boundary_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
